// File: rtl/reg_write_tracker.sv
// Tracks the destination registers of in-flight writers in EX/MEM/WB and derives
// per-operand forwarding selects, a load-use stall and a saturating stall counter.
`timescale 1ns/1ps

module reg_write_tracker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic [4:0]       id_wreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] FwdReg = 2'd0;
    localparam logic [1:0] FwdEx  = 2'd1;
    localparam logic [1:0] FwdMem = 2'd2;
    localparam logic [1:0] FwdWb  = 2'd3;

    // Load flag matters only while the writer sits in EX; MEM/WB data is already available.
    logic       ex_v, ex_we, ex_ld;
    logic [4:0] ex_dest;
    logic       mem_v, mem_we;
    logic [4:0] mem_dest;
    logic       wb_v, wb_we;
    logic [4:0] wb_dest;

    logic ex_hit_a, mem_hit_a, wb_hit_a;
    logic ex_hit_b, mem_hit_b, wb_hit_b;
    logic haz_a, haz_b, hazard;
    logic ex_load;

    function automatic logic slot_writes(input logic v, input logic we,
                                         input logic [4:0] dest, input logic [4:0] r);
        return v & we & (dest == r) & (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic haz,
                                           input logic ex_hit, input logic ld,
                                           input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FwdReg;
        if (!used || haz) begin
            sel = FwdReg;
        end else if (ex_hit && !ld) begin
            sel = FwdEx;
        end else if (mem_hit) begin
            sel = FwdMem;
        end else if (wb_hit) begin
            sel = FwdWb;
        end
        return sel;
    endfunction

    always_comb begin
        ex_hit_a  = slot_writes(ex_v, ex_we, ex_dest, id_rs);
        mem_hit_a = slot_writes(mem_v, mem_we, mem_dest, id_rs);
        wb_hit_a  = slot_writes(wb_v, wb_we, wb_dest, id_rs);
        ex_hit_b  = slot_writes(ex_v, ex_we, ex_dest, id_rt);
        mem_hit_b = slot_writes(mem_v, mem_we, mem_dest, id_rt);
        wb_hit_b  = slot_writes(wb_v, wb_we, wb_dest, id_rt);

        haz_a  = id_r1_used & ex_hit_a & ex_ld;
        haz_b  = id_r2_used & ex_hit_b & ex_ld;
        hazard = haz_a | haz_b;

        stall = hazard & id_valid & ~flush & ~halt;
        fwd_a = fwd_sel(id_r1_used, haz_a, ex_hit_a, ex_ld, mem_hit_a, wb_hit_a);
        fwd_b = fwd_sel(id_r2_used, haz_b, ex_hit_b, ex_ld, mem_hit_b, wb_hit_b);

        ex_load = id_valid & ~flush & ~stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v     <= 1'b0;
            ex_dest  <= 5'd0;
            ex_we    <= 1'b0;
            ex_ld    <= 1'b0;
            mem_v    <= 1'b0;
            mem_dest <= 5'd0;
            mem_we   <= 1'b0;
            wb_v     <= 1'b0;
            wb_dest  <= 5'd0;
            wb_we    <= 1'b0;
        end else if (!halt) begin
            wb_v     <= mem_v;
            wb_dest  <= mem_dest;
            wb_we    <= mem_we;
            mem_v    <= ex_v;
            mem_dest <= ex_dest;
            mem_we   <= ex_we;
            if (ex_load) begin
                ex_v    <= 1'b1;
                ex_dest <= id_wreg;
                ex_we   <= id_regwrite;
                ex_ld   <= id_memread;
            end else begin
                ex_v    <= 1'b0;
                ex_dest <= 5'd0;
                ex_we   <= 1'b0;
                ex_ld   <= 1'b0;
            end
        end
    end

    // stall already folds in ~halt, so a frozen pipeline never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_reg_write_tracker.sv
// Scoreboard bench for reg_write_tracker: directed hazards plus random traffic checked
// against a history-list model of the last three issued instructions.
`timescale 1ns/1ps

module tb_reg_write_tracker;

    logic        clk, rst, halt, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_wreg;
    logic        id_r1_used, id_r2_used, id_regwrite, id_memread;
    logic        stall, stall2;
    logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic [15:0] count16;
    logic [1:0]  count2;

    reg_write_tracker #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .halt(halt), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(count16)
    );

    reg_write_tracker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .halt(halt), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       we;
        bit       ld;
    } rec_t;

    typedef struct {
        bit       stall;
        bit [1:0] fa;
        bit [1:0] fb;
        int       c16;
        int       c2;
    } exp_t;

    rec_t hist [3];   // [0] = most recently issued (EX), [2] = oldest (WB)
    int   cnt16, cnt2;
    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) hist[i] = '{v: 0, d: 0, we: 0, ld: 0};
        cnt16 = 0;
        cnt2  = 0;
    endfunction

    // Youngest writer of r wins; a load still in EX cannot forward yet.
    function automatic void operand(input bit [4:0] r, input bit used,
                                    output bit haz, output bit [1:0] f);
        haz = 0;
        f   = 0;
        if (used && r != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (hist[i].v && hist[i].we && hist[i].d == r) begin
                    if (i == 0 && hist[i].ld) haz = 1;
                    else f = 2'(i + 1);
                    break;
                end
            end
        end
    endfunction

    function automatic exp_t predict(output bit st);
        exp_t e;
        bit ha, hb;
        bit [1:0] fa, fb;
        operand(id_rs, id_r1_used, ha, fa);
        operand(id_rt, id_r2_used, hb, fb);
        st = (ha || hb) && id_valid && !flush && !halt;
        e.stall = st;
        e.fa = fa;
        e.fb = fb;
        e.c16 = cnt16;
        e.c2 = cnt2;
        return e;
    endfunction

    task automatic apply(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                         input bit u1, input bit u2, input bit [4:0] wreg,
                         input bit we, input bit ld, input bit fl, input bit hl);
        exp_t e;
        bit st;
        rec_t nr;
        id_valid = v; id_rs = rs; id_rt = rt; id_r1_used = u1; id_r2_used = u2;
        id_wreg = wreg; id_regwrite = we; id_memread = ld; flush = fl; halt = hl;
        e = predict(st);
        sb.push_back(e);
        @(posedge clk);
        if (!rst && !hl) begin
            if (v && !fl && !st) nr = '{v: 1, d: wreg, we: we, ld: ld};
            else nr = '{v: 0, d: 0, we: 0, ld: 0};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nr;
            if (st) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt2 < 3) cnt2++;
            end
        end
        #1;
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        exp_t e;
        bit st;
        #1;
        rst = 1'b1;
        model_clear();
        e = predict(st);
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            chk("stall", int'(stall), int'(e.stall));
            chk("fwd_a", int'(fwd_a), int'(e.fa));
            chk("fwd_b", int'(fwd_b), int'(e.fb));
            chk("stall_count", int'(count16), e.c16);
            chk("stall_count_w2", int'(count2), e.c2);
            chk("stall_w2", int'(stall2), int'(e.stall));
            chk("fwd_a_w2", int'(fwd_a2), int'(e.fa));
            chk("fwd_b_w2", int'(fwd_b2), int'(e.fb));
        end
    end

    initial begin
        rst = 1'b1;
        halt = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_r1_used = 0;
        id_r2_used = 0; id_wreg = 0; id_regwrite = 0; id_memread = 0;
        model_clear();
        @(posedge clk);
        async_reset();

        // Idle after reset.
        for (int i = 0; i < 10; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // add $3 followed by readers at EX, MEM, WB distance.
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        apply(1, 3, 0, 1, 0, 9, 0, 0, 0, 0);
        apply(1, 3, 0, 1, 0, 10, 0, 0, 0, 0);
        apply(1, 3, 0, 1, 0, 11, 0, 0, 0, 0);

        // lw $5 then rt=5 reader: one stall, then MEM forward.
        apply(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        apply(1, 0, 5, 0, 1, 6, 1, 0, 0, 0);
        apply(1, 0, 5, 0, 1, 6, 1, 0, 0, 0);

        // $0 never matches; unused operand never forwards.
        apply(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 1, 1, 12, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        apply(1, 0, 3, 0, 0, 13, 0, 0, 0, 0);

        // Flush beats hazard; halt freezes slots for 3 cycles.
        apply(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        apply(1, 7, 0, 1, 0, 8, 1, 0, 1, 0);
        apply(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) apply(1, 7, 0, 1, 0, 8, 1, 0, 0, 1);
        apply(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        apply(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);

        // Five more load-use stalls drive the 2-bit counter into saturation.
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
            apply(1, 5, 0, 1, 0, 14, 1, 0, 0, 0);
        end

        // Mid-operation reset with a writer in flight.
        apply(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        async_reset();
        apply(1, 4, 6, 1, 1, 0, 0, 0, 0, 0);

        // Random traffic over a small register range so hits are frequent.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) async_reset();
            apply($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_tracker.md
Name: reg_write_tracker

Overview:
- Producer-side companion to the ID-stage register-read decoder: tracks the destination register of every in-flight writer in EX, MEM and WB.
- Compares those destinations against the ID-stage source registers, qualified by the r1/r2-used flags.
- Outputs per-operand forwarding selects, a load-use stall, and a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline register in the 5-stage MIPS pipeline CPU.

Parameters:
- CNT_W, 16, width of stall_count.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- halt  input  1  freeze: while high, no tracker state changes and the counter holds.
- flush  input  1  squash the ID instruction (taken branch/jump); EX receives a bubble.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  5  ID source register 1.
- id_rt  input  5  ID source register 2.
- id_r1_used  input  1  id_rs is actually read.
- id_r2_used  input  1  id_rt is actually read.
- id_wreg  input  5  ID destination register, already muxed rd/rt/31.
- id_regwrite  input  1  ID instruction writes the register file.
- id_memread  input  1  ID instruction is a load (lw).
- stall  output  1  hold PC and IF/ID, insert a bubble into EX.
- fwd_a  output  2  rs operand source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- fwd_b  output  2  rt operand source, same encoding as fwd_a.
- stall_count  output  CNT_W  number of stall cycles, saturating.

Behaviour:
- Internal state: three stage slots EX, MEM, WB. Each slot holds {v, dest[4:0], we, ld}.
- Slot "writes r" means v & we & (dest == r) & (r != 0). Register $0 never matches.
- Reset (async, rst=1): all slot v=0, dest=0, we=0, ld=0; stall_count=0. With no valid slots, combinational outputs are stall=0, fwd_a=0, fwd_b=0.
- Forward select for an operand (rs with r1_used, rt with r2_used), highest priority first:
  - EX writes r and EX.ld=0 → 1.
  - else MEM writes r → 2.
  - else WB writes r → 3.
  - else 0.
  - Operand not used → 0, regardless of matches.
- Load-use hazard: EX writes r, EX.ld=1, and the operand is used, for either rs or rt. While the hazard holds, the affected fwd field is 0; the other operand's field is computed normally.
- stall = hazard & id_valid & ~flush & ~halt. All outputs are combinational in the current state and inputs; zero latency.
- Clock edge with halt=1: nothing changes.
- Clock edge with halt=0:
  - WB ← MEM and MEM ← EX, always.
  - EX ← bubble (v=0) if flush or stall or ~id_valid; otherwise EX ← {1, id_wreg, id_regwrite, id_memread}.
- A load-use hazard lasts exactly one cycle. After the bubble, the load sits in MEM and the dependent operand gets fwd=2.
- Simultaneous flush and hazard: flush wins. stall=0, EX gets a bubble, no count.
- Counter: on each edge with stall=1, stall_count increments. It saturates at 2^CNT_W−1 and never wraps.
- Reset mid-operation clears all slots immediately, without waiting for a clock edge. In-flight writers are forgotten.
- Rising edge with rst=1: rst dominates.

Test Plan:
- Reset then idle, no valid instructions → stall=0, fwd_a=0, fwd_b=0, stall_count=0 for 10 cycles.
- Issue add $3 (wreg=3, we=1); next cycle ID reads rs=3 (r1_used=1) → fwd_a=1. One cycle later, with an unrelated instruction between, → fwd_a=2. Two later → fwd_a=3.
- Issue lw $5 (ld=1); next ID reads rt=5 (r2_used=1) → stall=1 for exactly one cycle, stall_count 0→1. Following cycle: stall=0, fwd_b=2.
- Issue add $0 (we=1), then ID reads rs=0 → fwd_a=0, stall=0. Also: ID reads rt=3 with r2_used=0 while $3 is in EX → fwd_b=0.
- lw $7 in EX with ID reading rs=7 and flush=1 → stall=0, count unchanged, EX bubble. Same hazard with halt=1 → stall=0, slots frozen across 3 cycles.
- CNT_W=2: force 5 consecutive load-use stalls → stall_count reads 1, 2, 3, 3, 3. Assert rst mid-sequence without a clock edge → stall_count=0 and all fwd=0 immediately.
